// File: rtl/ap3216_i2c_responder.sv
// AP3216 ambient-light sensor emulation as an I2C target.
// Define AP3216_RESP_PS_EN to serve PS data on registers 0x0E/0x0F.
`timescale 1ns/1ps
module ap3216_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1E,
  parameter int         FILT_CYCLES = 3
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] I_als_data,
  input  logic [9:0]  I_ps_data,
  output logic [7:0]  O_sys_cfg,
  output logic        O_busy
);

  localparam int CW = $clog2(FILT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, MACK, WAIT_STOP
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]    s1, s2, flt, flt_q;
  logic [CW-1:0] fcnt [2];

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1      <= '1;
      s2      <= '1;
      flt     <= '1;
      flt_q   <= '1;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      s1    <= {sda, scl};
      s2    <= s1;
      flt_q <= flt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == flt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CW'(FILT_CYCLES - 1)) begin
          flt[i]  <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + CW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, rise, fall, start_c, stop_c;
  assign scl_f   = flt[0];
  assign sda_f   = flt[1];
  assign rise    = scl_f & ~flt_q[0];
  assign fall    = ~scl_f & flt_q[0];
  assign start_c = scl_f & flt_q[0] & flt_q[1] & ~sda_f;
  assign stop_c  = scl_f & flt_q[0] & ~flt_q[1] & sda_f;

  state_t      st, nxt;
  logic [2:0]  bcnt, bcnt_n;
  logic [6:0]  sh, sh_n, tx, tx_n;
  logic [7:0]  ptr, ptr_n, cfg_n, byte_in;
  logic [7:0]  rd_addr, rd_val;
  logic [15:0] snap, als_src;
  logic        ph, ph_n, drv, drv_n;
  logic        rw, rw_n, busy_n, snap_ld;

  assign byte_in = {sh, sda_f};
  assign sda     = drv ? 1'b0 : 1'bz;
  assign rd_addr = (st == MACK) ? ptr + 8'd1 : ptr;
  // First byte of a read is served from the live inputs,
  // later bytes from the snapshot taken at the same edge.
  assign als_src = (st == ADDR_ACK) ? I_als_data : snap;

`ifdef AP3216_RESP_PS_EN
  logic [9:0] ps_snap, ps_src;
  assign ps_src = (st == ADDR_ACK) ? I_ps_data : ps_snap;
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)     ps_snap <= '0;
    else if (snap_ld) ps_snap <= I_ps_data;
  end
`else
  logic ps_unused;
  assign ps_unused = ^I_ps_data;
`endif

  always_comb begin
    rd_val = 8'h00;
    case (rd_addr)
      8'h00:   rd_val = O_sys_cfg;
      8'h0C:   rd_val = als_src[7:0];
      8'h0D:   rd_val = als_src[15:8];
`ifdef AP3216_RESP_PS_EN
      8'h0E:   rd_val = {4'b0, ps_src[3:0]};
      8'h0F:   rd_val = {2'b0, ps_src[9:4]};
`endif
      default: rd_val = 8'h00;
    endcase
  end

  always_comb begin
    nxt     = st;
    bcnt_n  = bcnt;
    sh_n    = sh;
    tx_n    = tx;
    ph_n    = ph;
    drv_n   = drv;
    ptr_n   = ptr;
    cfg_n   = O_sys_cfg;
    busy_n  = O_busy;
    rw_n    = rw;
    snap_ld = 1'b0;
    if (stop_c) begin
      nxt    = IDLE;
      drv_n  = 1'b0;
      busy_n = 1'b0;
    end else if (start_c) begin
      nxt    = ADDR;
      bcnt_n = 3'd0;
      drv_n  = 1'b0;
      ph_n   = 1'b0;
    end else begin
      unique case (st)
        IDLE, WAIT_STOP: ;
        ADDR: if (rise) begin
          sh_n   = {sh[5:0], sda_f};
          bcnt_n = bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            ph_n = 1'b0;
            if (sh == DEV_ADDR) begin
              nxt    = ADDR_ACK;
              rw_n   = sda_f;
              busy_n = 1'b1;
            end else begin
              nxt = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: if (fall) begin
          if (!ph) begin
            drv_n = 1'b1;
            ph_n  = 1'b1;
          end else begin
            ph_n   = 1'b0;
            bcnt_n = 3'd0;
            if (rw) begin
              nxt     = RDATA;
              snap_ld = 1'b1;
              tx_n    = rd_val[6:0];
              drv_n   = ~rd_val[7];
            end else begin
              nxt   = REG;
              drv_n = 1'b0;
            end
          end
        end
        REG: if (rise) begin
          sh_n   = {sh[5:0], sda_f};
          bcnt_n = bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            ptr_n = byte_in;
            nxt   = REG_ACK;
            ph_n  = 1'b0;
          end
        end
        REG_ACK, WDATA_ACK: if (fall) begin
          if (!ph) begin
            drv_n = 1'b1;
            ph_n  = 1'b1;
          end else begin
            drv_n  = 1'b0;
            ph_n   = 1'b0;
            bcnt_n = 3'd0;
            nxt    = WDATA;
          end
        end
        WDATA: if (rise) begin
          sh_n   = {sh[5:0], sda_f};
          bcnt_n = bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            if (ptr == 8'h00) cfg_n = byte_in;
            ptr_n = ptr + 8'd1;
            nxt   = WDATA_ACK;
            ph_n  = 1'b0;
          end
        end
        RDATA: begin
          if (rise) begin
            bcnt_n = bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              nxt  = MACK;
              ph_n = 1'b0;
            end
          end else if (fall) begin
            tx_n  = {tx[5:0], 1'b0};
            drv_n = ~tx[6];
          end
        end
        MACK: begin
          if (fall && !ph) begin
            drv_n = 1'b0;
            ph_n  = 1'b1;
          end else if (rise && ph && sda_f) begin
            nxt  = WAIT_STOP;
            ph_n = 1'b0;
          end else if (fall && ph) begin
            ptr_n  = ptr + 8'd1;
            tx_n   = rd_val[6:0];
            drv_n  = ~rd_val[7];
            bcnt_n = 3'd0;
            ph_n   = 1'b0;
            nxt    = RDATA;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      st        <= IDLE;
      bcnt      <= '0;
      sh        <= '0;
      tx        <= '0;
      ph        <= 1'b0;
      drv       <= 1'b0;
      ptr       <= '0;
      O_sys_cfg <= '0;
      O_busy    <= 1'b0;
      rw        <= 1'b0;
    end else begin
      st        <= nxt;
      bcnt      <= bcnt_n;
      sh        <= sh_n;
      tx        <= tx_n;
      ph        <= ph_n;
      drv       <= drv_n;
      ptr       <= ptr_n;
      O_sys_cfg <= cfg_n;
      O_busy    <= busy_n;
      rw        <= rw_n;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)     snap <= '0;
    else if (snap_ld) snap <= I_als_data;
  end

endmodule

// File: doc/ap3216_i2c_responder.md
# ap3216_i2c_responder

I2C target that emulates the AP3216 ambient-light sensor. It is the responder end of the link driven by our AP3216 I2C controller (`AP3216_driver`). Used in simulation and on the bench to close the brightness loop without the physical sensor. It answers address, register-pointer, write and auto-incrementing read transactions, and serves ALS data taken from a host-supplied value.

## Interface
Parameters:
- `DEV_ADDR`, 7'h1E: 7-bit target address.
- `FILT_CYCLES`, 3: number of consecutive identical synchronized samples required before a filtered SCL/SDA level changes.

Ports:
- `I_clk`, input, 1: system clock, 50 MHz.
- `I_rst_n`, input, 1: asynchronous, active-low reset.
- `scl`, input, 1: I2C clock from the controller.
- `sda`, inout, 1: open-drain data line. The block drives only 0 or z.
- `I_als_data`, input, 16: ALS value served on registers 0x0C (low byte) and 0x0D (high byte).
- `I_ps_data`, input, 10: PS value, used only with `AP3216_RESP_PS_EN`.
- `O_sys_cfg`, output, 8: last value written to register 0x00.
- `O_busy`, output, 1: high from an addressed START until STOP.

## Operation
- **Input conditioning**
  - SCL and SDA each pass a 2-flop synchronizer, then a `FILT_CYCLES` stability filter.
  - Edges are detected on the filtered levels only.
- **Bus conditions** (filtered levels)
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit timing**
  - Bits are sampled on SCL rise, MSB first.
  - The SDA drive level changes only on SCL fall.
- **FSM states:** IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT_STOP.
- **Transitions**
  - IDLE → ADDR on START.
  - ADDR, after 8 bits:
    - Address matches `DEV_ADDR` → ADDR_ACK.
    - Address does not match → WAIT_STOP, SDA released.
  - ADDR_ACK:
    - Write bit → REG.
    - Read bit → RDATA. The first byte is loaded on the SCL fall that ends the ACK.
  - REG: captures the 8-bit pointer, then REG_ACK → WDATA.
  - WDATA: after 8 bits, write the byte at the pointer, increment the pointer, then WDATA_ACK → WDATA.
  - RDATA: after 8 bits, release SDA → MACK.
    - Controller ACK (SDA=0): increment the pointer, load the next byte, → RDATA.
    - Controller NACK: → WAIT_STOP.
  - START in any state (repeated start) → ADDR, with the pointer preserved.
  - STOP in any state → IDLE, SDA released.
- **ACK drive:** hold SDA low from the SCL fall after bit 8 until the SCL fall after bit 9.
- **Register map**
  - 0x00: read/write, returns `O_sys_cfg`.
  - 0x0C / 0x0D: ALS low / high bytes.
  - 0x0E / 0x0F: PS registers (see Configuration).
  - All other addresses read 0x00. Writes to them are ACKed and discarded.
- **ALS snapshot:** `I_als_data` is latched into a snapshot register at the SCL fall ending a read-address ACK. All reads within that transaction return the snapshot, so the 16-bit value stays coherent.
- **Pointer:** 8-bit, wraps from 0xFF to 0x00.
- **Reset values:** `O_sys_cfg`=0x00, `O_busy`=0, SDA released (z), pointer=0x00, snapshot=0x0000, FSM=IDLE.

## Timing
- Filtered levels lag the pins by 2+`FILT_CYCLES` clocks (5 at the defaults).
- SDA is pulled low or released no later than 2+`FILT_CYCLES`+1 clocks after a pin-level SCL fall. SCL low time must be at least 8 `I_clk` cycles; this is met by 100 and 400 kHz buses at 50 MHz.
- `O_sys_cfg` updates 1 clock after the filtered SCL rise that samples bit 0 of the write byte.
- `O_busy` rises 1 clock after the address-ACK decision and falls 1 clock after STOP detection.
- START and STOP on the same filtered sample cannot occur. If SDA toggles while SCL is high mid-byte, the START/STOP rule governs and any partial byte is discarded.
- Asserting reset mid-transaction releases SDA immediately (asynchronously) and restores all reset values.

## Configuration
- Macro: `AP3216_RESP_PS_EN`.
- **Defined:**
  - 0x0E returns `{4'b0, I_ps_data[3:0]}`.
  - 0x0F returns `{2'b0, I_ps_data[9:4]}`.
  - `I_ps_data` is snapshotted together with the ALS value.
- **Undefined:** 0x0E and 0x0F read 0x00, and `I_ps_data` is ignored with no PS flops synthesized.

## Test plan
- **Write config:** controller writes 0x3C, 0x00, 0x03, STOP → three ACKs, `O_sys_cfg`=0x03, `O_busy` returns to 0.
- **ALS read:** with `I_als_data`=0xA55A, controller writes pointer 0x0C, repeated start, sends 0x3D, reads 2 bytes (ACK then NACK), STOP → data 0x5A, 0xA5.
- **Snapshot coherency:** same transaction as the ALS read, but `I_als_data` changes to 0x1234 between the two bytes → data still 0x5A, 0xA5.
- **Wrong address:** controller sends 0x40 → SDA never driven low, FSM in WAIT_STOP until STOP, `O_busy`=0.
- **Pointer wrap:** set pointer to 0xFF, read 2 bytes → 0x00 (reg 0xFF), then `O_sys_cfg` (reg 0x00).
- **Reset mid-ACK:** pulse `I_rst_n` low while SDA is held low during an ACK → SDA z within the same cycle, `O_sys_cfg`=0x00, next START is accepted normally.
